// File: rtl/boron_dec_key_schedule.sv
// Boron decryption key schedule.
// Expands the 80-bit master key K0 forward to K_ROUNDS, then walks backward
// one round key per next_i request, presenting K_r to the add-round-key stage.
module boron_dec_key_schedule #(
  parameter int ROUNDS = 25,
  parameter int RC_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [79:0]     key_i,
  input  logic            key_load_i,
  input  logic            next_i,
  output logic [79:0]     current_key_o,
  output logic [RC_W-1:0] round_o,
  output logic            busy_o,
  output logic            key_valid_o,
  output logic            last_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

  // 4-bit forward S-box applied to the low nibble of the rotated key.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  // Inverse of sbox, used when stepping the schedule backward.
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hA;  4'h1: y = 4'h3;  4'h2: y = 4'h9;  4'h3: y = 4'hE;
      4'h4: y = 4'h1;  4'h5: y = 4'hD;  4'h6: y = 4'hF;  4'h7: y = 4'h4;
      4'h8: y = 4'hC;  4'h9: y = 4'h5;  4'hA: y = 4'h7;  4'hB: y = 4'h2;
      4'hC: y = 4'h6;  4'hD: y = 4'h8;  4'hE: y = 4'h0;  default: y = 4'hB;
    endcase
    return y;
  endfunction

  // Forward round update: rotate left 13, S-box low nibble, mix in rc.
  function automatic logic [79:0] f_update(input logic [79:0] k,
                                           input logic [RC_W-1:0] rc);
    logic [79:0] t;
    t = {k[66:0], k[79:67]};
    t[3:0] = sbox(t[3:0]);
    t[63:64-RC_W] = t[63:64-RC_W] ^ rc;
    return t;
  endfunction

  // Inverse round update: undo rc, undo S-box, rotate right 13.
  function automatic logic [79:0] g_update(input logic [79:0] k,
                                           input logic [RC_W-1:0] rc);
    logic [79:0] t;
    t = k;
    t[63:64-RC_W] = t[63:64-RC_W] ^ rc;
    t[3:0] = sbox_inv(t[3:0]);
    return {t[12:0], t[79:13]};
  endfunction

  state_t          state_q;
  logic [79:0]     key_q;
  logic [RC_W-1:0] round_q;
  logic            busy_q;
  logic            valid_q;
  logic            last_q;
  logic [79:0]     fwd_key_d;
  logic [79:0]     inv_key_d;

  // Candidate next keys for both directions, keyed by the current round counter.
  always_comb begin
    fwd_key_d = f_update(key_q, round_q);
    inv_key_d = g_update(key_q, round_q);
  end

  // Schedule FSM: load / expand forward / step backward, all outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (key_load_i) begin
      // A load restarts from any state and wins over a simultaneous next_i.
      state_q <= EXPAND;
      key_q   <= key_i;
      round_q <= RC_ONE;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Hold everything until a key is loaded.
        end
        EXPAND: begin
          key_q <= fwd_key_d;
          if (round_q == RC_LAST) begin
            // round_q already equals ROUNDS, which is the index of the key just made.
            state_q <= READY;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            last_q  <= (RC_LAST == '0);
          end else begin
            round_q <= round_q + RC_ONE;
          end
        end
        READY: begin
          if (next_i && (round_q != '0)) begin
            key_q   <= inv_key_d;
            round_q <= round_q - RC_ONE;
            last_q  <= (round_q == RC_ONE);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign current_key_o = key_q;
  assign round_o       = round_q;
  assign busy_o        = busy_q;
  assign key_valid_o   = valid_q;
  assign last_o        = last_q;

endmodule

// File: tb/tb_boron_dec_key_schedule.sv
// Self-checking bench for boron_dec_key_schedule: randomized keys checked
// against a forward-only key list built from the round rules.
module tb_boron_dec_key_schedule;

  localparam int RC_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance, ROUNDS = 25.
  logic [79:0]     key;
  logic            load;
  logic            nxt;
  logic [79:0]     cur_key;
  logic [RC_W-1:0] rnd;
  logic            busy, valid, last;

  // Small instance, ROUNDS = 1.
  logic [79:0]     key1;
  logic            load1;
  logic            nxt1;
  logic [79:0]     cur_key1;
  logic [RC_W-1:0] rnd1;
  logic            busy1, valid1, last1;

  boron_dec_key_schedule #(.ROUNDS(25), .RC_W(RC_W)) dut (
    .clk(clk), .rst(rst), .key_i(key), .key_load_i(load), .next_i(nxt),
    .current_key_o(cur_key), .round_o(rnd), .busy_o(busy),
    .key_valid_o(valid), .last_o(last)
  );

  boron_dec_key_schedule #(.ROUNDS(1), .RC_W(RC_W)) dut1 (
    .clk(clk), .rst(rst), .key_i(key1), .key_load_i(load1), .next_i(nxt1),
    .current_key_o(cur_key1), .round_o(rnd1), .busy_o(busy1),
    .key_valid_o(valid1), .last_o(last1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: list of round keys K0..K25 from the forward rule only.
  logic [3:0]  sbox_tbl [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                 4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  logic [79:0] model_keys [0:25];

  function automatic logic [79:0] model_fwd(input logic [79:0] k, input int rc);
    logic [79:0] t;
    logic [79:0] rc80;
    t = (k << 13) | (k >> 67);
    t = {t[79:4], sbox_tbl[t[3:0]]};
    rc80 = 80'(rc);
    return t ^ (rc80 << 59);
  endfunction

  task automatic build_model(input logic [79:0] k0);
    model_keys[0] = k0;
    for (int i = 1; i <= 25; i++) model_keys[i] = model_fwd(model_keys[i-1], i);
  endtask

  function automatic logic [79:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high, starting just after the load edge.
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; nxt = 1'b1; key = rand_key();
    load1 = 1'b1; nxt1 = 1'b1; key1 = rand_key();
    tick(); tick();
    n_cmp++; if ({cur_key, rnd, busy, valid, last} !== '0) begin
      n_bad++; $display("FAIL reset25 got key=%h r=%0d b=%b v=%b l=%b want all zero",
                        cur_key, rnd, busy, valid, last);
    end
    n_cmp++; if ({cur_key1, rnd1, busy1, valid1, last1} !== '0) begin
      n_bad++; $display("FAIL reset1 got key=%h r=%0d b=%b v=%b l=%b want all zero",
                        cur_key1, rnd1, busy1, valid1, last1);
    end
    rst = 1'b0; load = 1'b0; nxt = 1'b0; load1 = 1'b0; nxt1 = 1'b0;
  endtask

  task automatic test_rounds1();
    logic [79:0] exp_k1;
    exp_k1 = 80'h0000_0800_0000_0000_000E;
    key1 = '0; load1 = 1'b1; tick(); load1 = 1'b0;
    tick();
    n_cmp++; if (cur_key1 !== exp_k1 || rnd1 !== 5'd1 || valid1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL r1_expand got key=%h r=%0d v=%b b=%b want key=%h r=1 v=1 b=0",
                        cur_key1, rnd1, valid1, busy1, exp_k1);
    end
    nxt1 = 1'b1; tick(); nxt1 = 1'b0;
    n_cmp++; if (cur_key1 !== 80'h0 || rnd1 !== 5'd0 || last1 !== 1'b1) begin
      n_bad++; $display("FAIL r1_step got key=%h r=%0d l=%b want key=0 r=0 l=1",
                        cur_key1, rnd1, last1);
    end
  endtask

  task automatic test_full_walk();
    int cyc;
    logic [79:0] k0;
    k0 = rand_key();
    build_model(k0);
    key = k0; load = 1'b1; tick(); load = 1'b0;
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL walk_start got v=%b b=%b want v=0 b=1", valid, busy);
    end
    count_busy(cyc);
    n_cmp++; if (cyc !== 25) begin
      n_bad++; $display("FAIL walk_busy got %0d cycles want 25", cyc);
    end
    n_cmp++; if (cur_key !== model_keys[25] || rnd !== 5'd25 || valid !== 1'b1 || last !== 1'b0) begin
      n_bad++; $display("FAIL walk_k25 got key=%h r=%0d v=%b l=%b want key=%h r=25 v=1 l=0",
                        cur_key, rnd, valid, last, model_keys[25]);
    end
    nxt = 1'b1;
    for (int r = 24; r >= 0; r--) begin
      tick();
      n_cmp++; if (cur_key !== model_keys[r] || rnd !== 5'(r) || last !== (r == 0) || valid !== 1'b1) begin
        n_bad++; $display("FAIL walk_step got key=%h r=%0d l=%b v=%b want key=%h r=%0d",
                          cur_key, rnd, last, valid, model_keys[r], r);
      end
    end
    n_cmp++; if (cur_key !== k0) begin
      n_bad++; $display("FAIL walk_k0 got key=%h want %h", cur_key, k0);
    end
  endtask

  task automatic test_boundary();
    logic [79:0] k0;
    k0 = model_keys[0];
    nxt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (cur_key !== k0 || rnd !== 5'd0 || last !== 1'b1 || valid !== 1'b1) begin
        n_bad++; $display("FAIL boundary got key=%h r=%0d l=%b v=%b want key=%h r=0 l=1 v=1",
                          cur_key, rnd, last, valid, k0);
      end
    end
    nxt = 1'b0;
  endtask

  task automatic test_restart();
    int cyc;
    logic [79:0] ka, kb;
    ka = rand_key();
    kb = rand_key();
    key = ka; load = 1'b1; tick(); load = 1'b0;
    repeat (9) tick();
    key = kb; load = 1'b1; tick(); load = 1'b0;
    build_model(kb);
    count_busy(cyc);
    n_cmp++; if (cyc !== 25) begin
      n_bad++; $display("FAIL restart_busy got %0d cycles want 25", cyc);
    end
    n_cmp++; if (cur_key !== model_keys[25] || rnd !== 5'd25 || valid !== 1'b1) begin
      n_bad++; $display("FAIL restart_k25 got key=%h r=%0d v=%b want key=%h r=25 v=1",
                        cur_key, rnd, valid, model_keys[25]);
    end
  endtask

  task automatic test_load_next();
    int cyc;
    logic [79:0] kc;
    kc = rand_key();
    key = kc; load = 1'b1; nxt = 1'b1; tick(); load = 1'b0; nxt = 1'b0;
    n_cmp++; if (valid !== 1'b0 || rnd !== 5'd1 || busy !== 1'b1 || cur_key !== kc) begin
      n_bad++; $display("FAIL load_vs_next got v=%b r=%0d b=%b key=%h want v=0 r=1 b=1 key=%h",
                        valid, rnd, busy, cur_key, kc);
    end
    build_model(kc);
    count_busy(cyc);
    n_cmp++; if (cyc !== 25 || cur_key !== model_keys[25] || rnd !== 5'd25) begin
      n_bad++; $display("FAIL load_vs_next_k25 got cyc=%0d key=%h r=%0d want cyc=25 key=%h r=25",
                        cyc, cur_key, rnd, model_keys[25]);
    end
    // next_i while idle-in-EXPAND must be ignored: issue it mid-expansion.
    key = rand_key(); build_model(key);
    load = 1'b1; tick(); load = 1'b0; nxt = 1'b1;
    count_busy(cyc);
    nxt = 1'b0;
    n_cmp++; if (cyc !== 25 || cur_key !== model_keys[25] || rnd !== 5'd25) begin
      n_bad++; $display("FAIL next_in_expand got cyc=%0d key=%h r=%0d want cyc=25 key=%h r=25",
                        cyc, cur_key, rnd, model_keys[25]);
    end
  endtask

  initial begin
    rst = 1'b1; key = '0; load = 1'b0; nxt = 1'b0;
    key1 = '0; load1 = 1'b0; nxt1 = 1'b0;
    test_reset();
    test_rounds1();
    test_full_walk();
    test_boundary();
    test_restart();
    test_load_next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boron_dec_key_schedule.md
Name: boron_dec_key_schedule

Overview:
- Sequential 80-bit key schedule feeding the Boron decryption datapath.
- Takes the master key K0 and expands it forward to the final round key K_ROUNDS.
- Then, on each request, steps backward one round key at a time, K_ROUNDS down to K0.
- Drives current_key of the decryption add-round-key stage, which XORs key bits [63:0] into the 64-bit state.

Parameters:
- ROUNDS, 25, number of Boron rounds; forward expansion length and start value of the round counter.
- RC_W, 5, width of the round counter and of the round-constant field XORed into key bits [63:59].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_i  input  80  master key K0; sampled when key_load_i=1.
- key_load_i  input  1  one-cycle pulse; captures key_i and starts forward expansion.
- next_i  input  1  request to step current_key_o to the previous round key.
- current_key_o  output  80  round key presented to the decryption add-round-key stage.
- round_o  output  RC_W  index r of current_key_o (current_key_o = K_r).
- busy_o  output  1  forward expansion in progress.
- key_valid_o  output  1  current_key_o holds a valid K_r.
- last_o  output  1  key_valid_o=1 and r=0 (K0 presented).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, current_key_o=0, round_o=0, busy_o=0, key_valid_o=0, last_o=0.
  - Reset dominates all other inputs.
- Forward update F(K, rc):
  - T = K rotated left 13.
  - T[3:0] = S(T[3:0]), with S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}.
  - T[63:59] ^= rc.
- Inverse update G(K, rc):
  - T = K.
  - T[63:59] ^= rc.
  - T[3:0] = Sinv(T[3:0]), with Sinv = {A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B}.
  - Result = T rotated right 13.
  - G(F(K, rc), rc) = K for all K and rc.
- FSM states: IDLE, EXPAND, READY.
- IDLE:
  - Outputs hold their values.
  - key_load_i → load key_i into the key register, rc=1, go to EXPAND.
  - key_valid_o=0 from the next cycle.
- EXPAND:
  - Each cycle: key=F(key, rc), rc++.
  - After the cycle with rc=ROUNDS → READY, with round_o=ROUNDS and key_valid_o=1.
  - busy_o=1 throughout.
  - Latency: key_load_i at edge t → K_ROUNDS valid after edge t+ROUNDS, i.e. ROUNDS+1 cycles after the pulse.
- READY:
  - next_i with r>0: key=G(key, r), r--; the new key is visible on the next cycle.
  - next_i with r=0: ignored; key stays K0, last_o stays 1.
- key_load_i in any state, including mid-EXPAND or mid-stepping:
  - Restarts from key_i, drops key_valid_o next cycle.
  - Takes priority over a simultaneous next_i.
- next_i outside READY is ignored.
- All outputs are registered; no combinational input-to-output path.
- Round-constant width rule: rc is zero-extended to RC_W; with ROUNDS=25 the maximum value is 25, which fits in 5 bits.

Test Plan:
- Reset: assert rst for 2 cycles with key_load_i=1 and next_i=1 → current_key_o=0, round_o=0, busy_o=0, key_valid_o=0, last_o=0.
- ROUNDS=1, key_i=0, key_load_i pulse:
  - After 2 cycles current_key_o=0x0000_0800_0000_0000_000E, round_o=1.
  - Then next_i → current_key_o=0, round_o=0, last_o=1.
- ROUNDS=25 with a random key:
  - busy_o is high for exactly 25 cycles.
  - K25 matches the software model.
  - 25 consecutive next_i pulses walk round_o 25→0 with keys matching the model at every step, ending at current_key_o=key_i.
- Boundary at r=0: hold next_i=1 for 5 extra cycles → current_key_o stays K0, round_o=0, last_o=1.
- Restart mid-EXPAND (cycle 10 of 25): pulse key_load_i with a new key → busy_o stays high for 25 more cycles; the final key is derived only from the new key.
- Simultaneous key_load_i and next_i in READY: load wins; key_valid_o=0 next cycle; round_o does not decrement.
